// File: rtl/branch_ctrl.sv
`timescale 1ns/1ps
// Branch resolution and fetch-redirect controller: flag register, condition
// evaluation, redirect handshake sequencing and saturating branch counters.
module branch_ctrl #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [2:0]        flag_we,
    input  logic              alu_n,
    input  logic              alu_z,
    input  logic              alu_v,
    input  logic              br_valid,
    input  logic [2:0]        br_cond,
    input  logic [ADDR_W-1:0] br_target,
    input  logic              redir_ready,
    input  logic              cnt_clr,
    output logic              redir_valid,
    output logic [ADDR_W-1:0] redir_pc,
    output logic              flush,
    output logic              stall_ex,
    output logic              n_flag,
    output logic              z_flag,
    output logic              v_flag,
    output logic [CNT_W-1:0]  br_total,
    output logic [CNT_W-1:0]  br_taken
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REDIR = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t              state_q;
    logic                n_q, z_q, v_q;
    logic [ADDR_W-1:0]   pc_q;
    logic                redir_valid_q, flush_q, stall_q;
    logic [CNT_W-1:0]    total_q, taken_q;
    logic                taken_c;
    logic                accept_c;

    // Condition evaluated on the registered flags, so a same-cycle write is not seen.
    always_comb begin
        taken_c = 1'b0;
        case (br_cond)
            3'b000:  taken_c = ~z_q;
            3'b001:  taken_c = z_q;
            3'b010:  taken_c = ~z_q & ~n_q;
            3'b011:  taken_c = n_q;
            3'b100:  taken_c = z_q | (~z_q & ~n_q);
            3'b101:  taken_c = n_q | z_q;
            3'b110:  taken_c = v_q;
            default: taken_c = 1'b1;
        endcase
    end

    assign accept_c = br_valid && (state_q == IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            n_q <= 1'b0;
            z_q <= 1'b0;
            v_q <= 1'b0;
        end else begin
            if (flag_we[2]) n_q <= alu_n;
            if (flag_we[1]) z_q <= alu_z;
            if (flag_we[0]) v_q <= alu_v;
        end
    end

    // Redirect sequencer; flush stays high from REDIR through the one DRAIN cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            pc_q          <= '0;
            redir_valid_q <= 1'b0;
            flush_q       <= 1'b0;
            stall_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (br_valid && taken_c) begin
                        state_q       <= REDIR;
                        pc_q          <= br_target;
                        redir_valid_q <= 1'b1;
                        flush_q       <= 1'b1;
                        stall_q       <= 1'b1;
                    end
                end
                REDIR: begin
                    if (redir_ready) begin
                        state_q       <= DRAIN;
                        redir_valid_q <= 1'b0;
                        stall_q       <= 1'b0;
                    end
                end
                DRAIN: begin
                    state_q <= IDLE;
                    flush_q <= 1'b0;
                end
                default: begin
                    state_q       <= IDLE;
                    redir_valid_q <= 1'b0;
                    flush_q       <= 1'b0;
                    stall_q       <= 1'b0;
                end
            endcase
        end
    end

    // Saturating performance counters; clear wins over a same-cycle increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            total_q <= '0;
            taken_q <= '0;
        end else if (cnt_clr) begin
            total_q <= '0;
            taken_q <= '0;
        end else if (accept_c) begin
            if (total_q != '1) total_q <= total_q + CNT_W'(1);
            if (taken_c && (taken_q != '1)) taken_q <= taken_q + CNT_W'(1);
        end
    end

    assign redir_valid = redir_valid_q;
    assign redir_pc    = pc_q;
    assign flush       = flush_q;
    assign stall_ex    = stall_q;
    assign n_flag      = n_q;
    assign z_flag      = z_q;
    assign v_flag      = v_q;
    assign br_total    = total_q;
    assign br_taken    = taken_q;

endmodule

// File: doc/branch_ctrl.md
# branch_ctrl

Branch resolution and redirect controller for the five-stage pipeline. It holds the architectural N/Z/V flag register and evaluates the 3-bit branch condition of the branch in EX against those flags. On a taken branch it sequences the fetch redirect with a valid/ready handshake, because fetch can be stalled by an I-cache miss, and it generates the IF/ID flush and EX stall around that redirect. It also keeps saturating branch and taken-branch counters for performance measurement.

## Interface
Parameters:
- ADDR_W, 16, PC/target width
- CNT_W, 16, performance counter width

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- flag_we  in  3  per-flag write enable {N,Z,V}; ADD/SUB assert 3'b111, logical ops assert 3'b010
- alu_n, alu_z, alu_v  in  1 each  flag values from the ALU in EX
- br_valid  in  1  branch instruction present in EX this cycle
- br_cond  in  3  branch condition code
- br_target  in  ADDR_W  branch target PC
- redir_ready  in  1  fetch accepts redirect; low during I-cache miss
- cnt_clr  in  1  synchronous clear of both counters
- redir_valid  out  1  redirect request to fetch
- redir_pc  out  ADDR_W  redirect target, stable while redir_valid
- flush  out  1  squash IF/ID contents
- stall_ex  out  1  hold EX and older stages
- n_flag, z_flag, v_flag  out  1 each  current flag register
- br_total, br_taken  out  CNT_W each  branch counters

## Operation
- Flag register: each flag loads its ALU value on the rising edge when its flag_we bit is set. Otherwise it holds.
- Condition codes, evaluated on the registered flags:
  - 000 NE: Z=0
  - 001 EQ: Z=1
  - 010 GT: Z=0 and N=0
  - 011 LT: N=1
  - 100 GE: Z=1 or (Z=0 and N=0)
  - 101 LE: N=1 or Z=1
  - 110 OV: V=1
  - 111 always
- Simultaneous flag_we and br_valid: the flag write completes, and the branch evaluates against the pre-write register value.
- FSM states:
  - IDLE: br_valid with a taken condition latches br_target into redir_pc and moves to REDIR. A not-taken branch or no branch stays in IDLE.
  - REDIR: redir_valid=1, flush=1, stall_ex=1. Stays while redir_ready=0. When redir_valid and redir_ready are both high on a clock edge, moves to DRAIN.
  - DRAIN: flush=1 and stall_ex=0 for exactly one cycle, to squash the wrong-path instruction in flight. Then returns to IDLE.
- br_valid is ignored in REDIR and DRAIN; the pipeline guarantees that no new branch reaches EX during those states.
- Counters, only for branches accepted in IDLE:
  - br_total increments on every br_valid.
  - br_taken increments on every taken branch.
  - Both saturate at all-ones.
  - cnt_clr takes priority over an increment in the same cycle.
- Reset, asynchronous and effective immediately:
  - state goes to IDLE.
  - All flags, redir_pc, and both counters go to 0.
  - redir_valid, flush, and stall_ex go to 0.
  - Reset mid-redirect abandons the redirect with no handshake.

## Timing
- Taken branch sampled at edge T: redir_valid, flush, and stall_ex are high from T+1.
- Earliest redirect acceptance is at edge T+2 (redir_ready high at T+1). DRAIN then runs during cycle T+2, and IDLE is reached at T+3.
- Each cycle that redir_ready stays low extends REDIR by one cycle. redir_pc is held constant throughout.
- Not-taken branch: zero penalty. No output changes except br_total, which updates at T+1.
- Flags written at edge T are visible on the outputs and to a branch sampled at edge T+1.
- All outputs are registered or decoded from state only; there is no combinational path from inputs to outputs.

## Test plan
- Reset and flag update:
  - Assert rst mid-REDIR → all outputs 0 immediately, state IDLE.
  - Then flag_we=010 with alu_z=1 → z_flag=1 next cycle, n_flag and v_flag unchanged.
- Condition sweep: for all 8 conditions × all 8 flag combinations, issue br_valid → taken exactly per the table. Check br_taken and br_total against a model count; 64 branches gives br_total=64.
- Redirect with miss: Z=1, br_cond=001, br_target=0x1234, redir_ready low for 3 cycles → redir_valid, flush, and stall_ex high for 4 cycles with redir_pc=0x1234. Then one DRAIN cycle with flush=1 and stall_ex=0, then IDLE.
- Simultaneous write and branch: Z=0, flag_we=010 with alu_z=1, and br_cond=001 in the same cycle → not taken, and z_flag=1 afterwards.
- Counter saturation and clear:
  - Preload near all-ones (CNT_W=4), issue 20 always-branches → both counters saturate at 0xF.
  - cnt_clr together with br_valid → both counters 0.
- Branch ignored during redirect: br_valid pulsed during REDIR and DRAIN → no counter change and no second redirect.
